counter_updown_t: RTL and testbench

Synchronous modulo-N up/down counter whose state bits are held in T flip-flop cells, one per bit. A combinational toggle-mask stage drives each cell's T input. The block consumes the T flip-flop primitive directly downstream: it produces the per-bit T stimulus and the cells' Q outputs form the count. It is the team's standard event/cycle counter for display and sequencing logic.

---
 rtl/counter_updown_t_pkg.sv | 13 +
 rtl/counter_updown_t_if.sv | 25 ++
 rtl/counter_updown_t_flipflop_t_sync_reset.sv | 22 ++
 rtl/counter_updown_t.sv | 92 +++++++++
 tb/tb_counter_updown_t.sv | 125 ++++++++++++
 5 files changed

// File: rtl/counter_updown_t_pkg.sv
// Shared constants and helpers for the modulo-N up/down T-cell counter.
// Direction encodings and the terminal-value helper live here so that the top and the bench agree on them.
package counter_updown_t_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Highest legal count for a given modulus; sized by the caller to WIDTH bits.
    function automatic int unsigned last_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/counter_updown_t_if.sv
// Control and status bundle for counter_updown_t.
// The master drives en/up/load/load_value and observes count/tc/wrap/load_err.
// There is no valid/ready handshake. The counter samples its controls on every rising clock edge.
interface counter_updown_t_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up, load, load_value,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_value,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/counter_updown_t_flipflop_t_sync_reset.sv
// T flip-flop cell with synchronous active-high reset.
// The cell toggles when t is 1 and holds when t is 0. q_inverse is always the complement of q.
module flipflop_t_sync_reset (
    input  logic t,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic q_inverse
);
    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q         = q_q;
    assign q_inverse = ~q_q;
endmodule

// File: rtl/counter_updown_t.sv
// Modulo-MODULUS up/down counter whose state is held in WIDTH T flip-flop cells.
// The next count is computed as a value, and each cell toggles exactly where that value differs from the current count.
module counter_updown_t
    import counter_updown_t_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           clk,
    input  logic           rst,
    counter_updown_t_if.slave bus
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(last_count(MODULUS));

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_qn;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] dec;
    logic             is_zero;
    logic             is_last;
    logic             wrap_d, wrap_q;
    logic             load_err_d, load_err_q;

    assign is_zero = &count_qn;
    assign is_last = (count_q == LAST);
    assign dec     = count_q - WIDTH'(1);

    // Terminal values are detected by comparing against LAST, never by carry-out.
    // This stays correct when MODULUS equals 2**WIDTH.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (rst) begin
            count_d = '0;
        end else if (bus.load) begin
            if (bus.load_value > LAST) begin
                count_d    = LAST;
                load_err_d = 1'b1;
            end else begin
                count_d = bus.load_value;
            end
        end else if (bus.en) begin
            if (bus.up == DIR_UP) begin
                if (count_q >= LAST) begin
                    count_d = '0;
                    wrap_d  = is_last;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (is_zero) begin
                    count_d = LAST;
                    wrap_d  = 1'b1;
                end else if (dec > LAST) begin
                    count_d = LAST;
                end else begin
                    count_d = dec;
                end
            end
        end
    end

    assign toggle = count_q ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        flipflop_t_sync_reset u_cell (
            .t         (toggle[i]),
            .clk       (clk),
            .rst       (rst),
            .q         (count_q[i]),
            .q_inverse (count_qn[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = bus.en & ~bus.load & ~rst &
                          ((bus.up == DIR_UP) ? is_last : is_zero);
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_counter_updown_t.sv
// Directed and randomized bench for counter_updown_t (WIDTH=4, MODULUS=10).
// Expected values come from an integer model of the counting rules.
module tb_counter_updown_t;
    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic clk = 1'b0;
    logic rst;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int m_count = 0;
    int m_wrap  = 0;
    int m_lerr  = 0;

    counter_updown_t_if #(.WIDTH(WIDTH)) bus ();

    counter_updown_t #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check tc before the edge and registered outputs after it
    task automatic apply(input logic r, input logic e, input logic u,
                         input logic l, input int lv);
        int exp_tc;
        rst            = r;
        bus.en         = e;
        bus.up         = u;
        bus.load       = l;
        bus.load_value = WIDTH'(lv);
        #2;
        exp_tc = (e && !l && !r && (u ? (m_count == MODULUS - 1) : (m_count == 0))) ? 1 : 0;
        chk("tc", {31'b0, bus.tc}, exp_tc);
        if (r) begin
            m_count = 0; m_wrap = 0; m_lerr = 0;
        end else if (l) begin
            m_wrap = 0;
            if (lv < MODULUS) begin m_count = lv; m_lerr = 0; end
            else begin m_count = MODULUS - 1; m_lerr = 1; end
        end else if (e) begin
            m_lerr = 0;
            if (u) begin
                m_wrap  = (m_count == MODULUS - 1) ? 1 : 0;
                m_count = (m_count + 1) % MODULUS;
            end else begin
                m_wrap  = (m_count == 0) ? 1 : 0;
                m_count = (m_count + MODULUS - 1) % MODULUS;
            end
        end else begin
            m_wrap = 0; m_lerr = 0;
        end
        @(posedge clk);
        #1;
        chk("count", {28'b0, bus.count}, m_count);
        chk("wrap", {31'b0, bus.wrap}, m_wrap);
        chk("load_err", {31'b0, bus.load_err}, m_lerr);
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_value = 4'd7;
        @(posedge clk); #1;

        // reset dominates load and enable
        apply(1, 1, 1, 1, 7);
        apply(1, 1, 1, 1, 7);
        chk("reset_count", {28'b0, bus.count}, 0);

        // up through the wrap: 1..9, 0, 1, 2
        for (int i = 0; i < 12; i++) apply(0, 1, 1, 0, 0);
        chk("up_final", {28'b0, bus.count}, 2);

        // down through the wrap: load 2 then 1, 0, 9, 8
        apply(0, 0, 1, 1, 2);
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 0, 0);
        chk("down_final", {28'b0, bus.count}, 8);

        // out-of-range load with en high clamps and flags, then an in-range load
        apply(0, 0, 1, 1, 5);
        apply(0, 1, 1, 1, 13);
        chk("clamp_count", {28'b0, bus.count}, 9);
        chk("clamp_err", {31'b0, bus.load_err}, 1);
        apply(0, 1, 1, 1, 3);
        chk("load3", {28'b0, bus.count}, 3);

        // hold, then direction flips each edge
        apply(0, 0, 1, 1, 4);
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0);
        chk("hold", {28'b0, bus.count}, 4);
        for (int i = 0; i < 4; i++) apply(0, 1, (i % 2 == 0), 0, 0);
        chk("flip", {28'b0, bus.count}, 4);

        // mid-count reset
        apply(0, 0, 1, 1, 6);
        apply(0, 1, 1, 0, 0);
        apply(1, 1, 1, 0, 0);
        apply(0, 1, 1, 0, 0);
        chk("post_reset", {28'b0, bus.count}, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
